// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall bus values, multi-cycle
// op kinds and the EX occupancy FSM states.
package pipe_ctrl_pkg;

  typedef logic [5:0] StallBus;

  localparam StallBus StallNone   = 6'b000000;
  localparam StallBus StallFromId = 6'b000111;
  localparam StallBus StallFromEx = 6'b001111;

  typedef enum logic {
    MulKind = 1'b0,
    DivKind = 1'b1
  } mc_kind_e;

  typedef enum logic [1:0] {
    McIdle = 2'd0,
    McBusy = 2'd1,
    McDone = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_counter.sv
// Down-counter tracking remaining EX busy cycles: load, decrement, clear and
// zero detect.
module mc_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over load so an aborted op never leaves a stale count behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges ID/EX stall requests and MEM flushes into the
// per-stage stall vector, and tracks multi-cycle EX ops.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        ex_mc_req_i,
  input  logic        ex_mc_kind_i,
  input  logic        flush_req_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        mc_busy_o,
  output logic        mc_done_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  mc_state_e        state;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_clear;
  logic [CNT_W-1:0] cnt_load_val;
  logic             ex_stall;
  StallBus          stall_d;
  logic [31:0]      stall_cnt_q;

  always_comb begin
    cnt_load     = (state == McIdle) && !flush_req_i && ex_mc_req_i;
    cnt_clear    = (state == McBusy) && flush_req_i;
    cnt_dec      = (state == McBusy) && !flush_req_i && !cnt_zero;
    cnt_load_val = (mc_kind_e'(ex_mc_kind_i) == DivKind) ? DivLoad : MulLoad;
  end

  mc_counter #(
    .CNT_W(CNT_W)
  ) u_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .zero     (cnt_zero)
  );

  // DONE ignores ex_mc_req_i: it still reflects the op that is completing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= McIdle;
    end else begin
      case (state)
        McIdle: if (!flush_req_i && ex_mc_req_i) state <= McBusy;
        McBusy: begin
          if (flush_req_i)   state <= McIdle;
          else if (cnt_zero) state <= McDone;
        end
        McDone:  state <= McIdle;
        default: state <= McIdle;
      endcase
    end
  end

  // Flush beats everything; an EX stall subsumes a concurrent ID stall.
  always_comb begin
    stall_d  = StallNone;
    ex_stall = ((state == McIdle) && ex_mc_req_i) || (state == McBusy);
    if (!rst)              stall_d = StallNone;
    else if (flush_req_i)  stall_d = StallNone;
    else if (ex_stall)     stall_d = StallFromEx;
    else if (stallreq_id_i) stall_d = StallFromId;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall_d[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_o     = stall_d;
  assign flush_o     = flush_req_i & rst;
  assign mc_busy_o   = (state == McBusy);
  assign mc_done_o   = (state == McDone) && !flush_req_i;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// against a timeline-based reference model.
module tb_pipe_ctrl;

  localparam int MulN = 3;
  localparam int DivN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i;
  logic        ex_mc_req_i;
  logic        ex_mc_kind_i;
  logic        flush_req_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        mc_busy_o;
  logic        mc_done_o;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: an op is a time window [start, end] where end is the
  // cycle of its done pulse.
  int          cyc;
  int          m_start;
  int          m_end;
  bit          m_active;
  longint      m_cnt;
  logic [5:0]  e_stall;
  logic        e_flush;
  logic        e_busy;
  logic        e_done;
  logic [31:0] e_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .MUL_CYCLES(MulN),
    .DIV_CYCLES(DivN),
    .CNT_W(6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id_i(stallreq_id_i),
    .ex_mc_req_i  (ex_mc_req_i),
    .ex_mc_kind_i (ex_mc_kind_i),
    .flush_req_i  (flush_req_i),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .mc_busy_o    (mc_busy_o),
    .mc_done_o    (mc_done_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  task automatic clear_inputs();
    stallreq_id_i = 1'b0;
    ex_mc_req_i   = 1'b0;
    ex_mc_kind_i  = 1'b0;
    flush_req_i   = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic model_step();
    bit ex_hold;
    e_flush = flush_req_i;
    e_cnt   = m_cnt[31:0];
    e_busy  = m_active && (cyc > m_start) && (cyc < m_end);
    e_done  = m_active && (cyc == m_end) && !flush_req_i;
    ex_hold = (m_active && (cyc < m_end)) || (!m_active && ex_mc_req_i);
    if (flush_req_i)        e_stall = 6'b000000;
    else if (ex_hold)       e_stall = 6'b001111;
    else if (stallreq_id_i) e_stall = 6'b000111;
    else                    e_stall = 6'b000000;
    if (e_stall[0] && (m_cnt < 64'hFFFF_FFFF)) m_cnt = m_cnt + 1;
    if (m_active) begin
      if (flush_req_i || (cyc == m_end)) m_active = 1'b0;
    end else if (ex_mc_req_i && !flush_req_i) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_end    = cyc + (ex_mc_kind_i ? DivN : MulN) + 1;
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    stallreq_id_i = 1'b1;
    ex_mc_req_i   = 1'b1;
    ex_mc_kind_i  = 1'b1;
    flush_req_i   = 1'b1;
    #2;
    checks++; if (stall_o !== 6'b0) begin failures++; $display("[TB] FAIL rst_stall got=%b exp=%b", stall_o, 6'b0); end
    checks++; if (flush_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_flush got=%b exp=0", flush_o); end
    checks++; if (mc_busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", mc_busy_o); end
    checks++; if (mc_done_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%b exp=0", mc_done_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_cnt got=%0d exp=0", stall_cnt_o); end
    apply_reset();
    @(negedge clk);
    checks++; if (stall_o !== 6'b0 || mc_busy_o !== 1'b0) begin failures++; $display("[TB] FAIL post_rst got stall=%b busy=%b exp stall=000000 busy=0", stall_o, mc_busy_o); end
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b1;
    repeat (12) next_cycle();
    @(negedge clk);
    checks++; if (mc_busy_o !== 1'b1 || stall_o !== 6'b001111) begin failures++; $display("[TB] FAIL midbusy_pre got busy=%b stall=%b exp busy=1 stall=001111", mc_busy_o, stall_o); end
    rst           = 1'b0;
    stallreq_id_i = 1'b1;
    flush_req_i   = 1'b1;
    #1;
    checks++; if (stall_o !== 6'b0) begin failures++; $display("[TB] FAIL midbusy_stall got=%b exp=000000", stall_o); end
    checks++; if (mc_busy_o !== 1'b0) begin failures++; $display("[TB] FAIL midbusy_busy got=%b exp=0", mc_busy_o); end
    checks++; if (flush_o !== 1'b0) begin failures++; $display("[TB] FAIL midbusy_flush got=%b exp=0", flush_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin failures++; $display("[TB] FAIL midbusy_cnt got=%0d exp=0", stall_cnt_o); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (mc_busy_o !== 1'b0 || stall_o !== 6'b0 || stall_cnt_o !== 32'd0) begin failures++; $display("[TB] FAIL midbusy_release got busy=%b stall=%b cnt=%0d exp 0/000000/0", mc_busy_o, stall_o, stall_cnt_o); end
  endtask

  task automatic test_multiply();
    apply_reset();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (stall_o !== ((c <= 3) ? 6'b001111 : 6'b000000)) begin failures++; $display("[TB] FAIL mul_stall c=%0d got=%b", c, stall_o); end
      checks++; if (mc_busy_o !== ((c >= 1) && (c <= 3))) begin failures++; $display("[TB] FAIL mul_busy c=%0d got=%b", c, mc_busy_o); end
      checks++; if (mc_done_o !== (c == 4)) begin failures++; $display("[TB] FAIL mul_done c=%0d got=%b", c, mc_done_o); end
      next_cycle();
    end
    ex_mc_req_i = 1'b0;
    @(negedge clk);
    checks++; if (stall_cnt_o !== 32'd4) begin failures++; $display("[TB] FAIL mul_cnt got=%0d exp=4", stall_cnt_o); end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    apply_reset();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b1;
    for (int c = 0; c < 68; c++) begin
      @(negedge clk);
      if (mc_done_o === 1'b1) dones++;
      checks++; if (stall_o !== (((c % 34) != 33) ? 6'b001111 : 6'b000000)) begin failures++; $display("[TB] FAIL b2b_stall c=%0d got=%b", c, stall_o); end
      next_cycle();
    end
    ex_mc_req_i = 1'b0;
    @(negedge clk);
    checks++; if (dones !== 2) begin failures++; $display("[TB] FAIL b2b_dones got=%0d exp=2", dones); end
    checks++; if (stall_cnt_o !== 32'd66) begin failures++; $display("[TB] FAIL b2b_cnt got=%0d exp=66", stall_cnt_o); end
  endtask

  task automatic test_load_use();
    apply_reset();
    stallreq_id_i = 1'b1;
    @(negedge clk);
    checks++; if (stall_o !== 6'b000111) begin failures++; $display("[TB] FAIL lu_stall got=%b exp=000111", stall_o); end
    next_cycle();
    stallreq_id_i = 1'b0;
    @(negedge clk);
    checks++; if (stall_o !== 6'b000000) begin failures++; $display("[TB] FAIL lu_after got=%b exp=000000", stall_o); end
    checks++; if (stall_cnt_o !== 32'd1) begin failures++; $display("[TB] FAIL lu_cnt got=%0d exp=1", stall_cnt_o); end
  endtask

  task automatic test_flush_abort();
    apply_reset();
    ex_mc_req_i  = 1'b1;
    ex_mc_kind_i = 1'b1;
    repeat (22) next_cycle();
    flush_req_i = 1'b1;
    ex_mc_req_i = 1'b0;
    @(negedge clk);
    checks++; if (flush_o !== 1'b1) begin failures++; $display("[TB] FAIL fl_flush got=%b exp=1", flush_o); end
    checks++; if (stall_o !== 6'b0) begin failures++; $display("[TB] FAIL fl_stall got=%b exp=000000", stall_o); end
    checks++; if (mc_done_o !== 1'b0) begin failures++; $display("[TB] FAIL fl_done got=%b exp=0", mc_done_o); end
    next_cycle();
    flush_req_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (mc_busy_o !== 1'b0 || mc_done_o !== 1'b0) begin failures++; $display("[TB] FAIL fl_idle c=%0d got busy=%b done=%b exp 0/0", c, mc_busy_o, mc_done_o); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (stall_cnt_o !== 32'd22) begin failures++; $display("[TB] FAIL fl_cnt got=%0d exp=22", stall_cnt_o); end
  endtask

  task automatic test_priority_sat();
    logic [31:0] exp_cnt;
    apply_reset();
    stallreq_id_i = 1'b1;
    ex_mc_req_i   = 1'b1;
    ex_mc_kind_i  = 1'b0;
    @(negedge clk);
    checks++; if (stall_o !== 6'b001111) begin failures++; $display("[TB] FAIL prio_stall got=%b exp=001111", stall_o); end
    apply_reset();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    stallreq_id_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (stall_cnt_o !== exp_cnt) begin failures++; $display("[TB] FAIL sat_cnt c=%0d got=%h exp=%h", c, stall_cnt_o, exp_cnt); end
      next_cycle();
      exp_cnt = 32'hFFFF_FFFF;
    end
    stallreq_id_i = 1'b0;
    @(negedge clk);
    checks++; if (stall_cnt_o !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat_final got=%h exp=ffffffff", stall_cnt_o); end
  endtask

  task automatic test_random();
    apply_reset();
    cyc      = 0;
    m_active = 1'b0;
    m_start  = 0;
    m_end    = 0;
    m_cnt    = 0;
    for (int i = 0; i < 400; i++) begin
      ex_mc_req_i   = ($urandom_range(0, 2) != 0);
      ex_mc_kind_i  = ($urandom_range(0, 3) == 0);
      stallreq_id_i = ($urandom_range(0, 3) == 0);
      flush_req_i   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      model_step();
      checks++; if (stall_o !== e_stall) begin failures++; $display("[TB] FAIL rnd_stall i=%0d got=%b exp=%b", i, stall_o, e_stall); end
      checks++; if (flush_o !== e_flush) begin failures++; $display("[TB] FAIL rnd_flush i=%0d got=%b exp=%b", i, flush_o, e_flush); end
      checks++; if (mc_busy_o !== e_busy) begin failures++; $display("[TB] FAIL rnd_busy i=%0d got=%b exp=%b", i, mc_busy_o, e_busy); end
      checks++; if (mc_done_o !== e_done) begin failures++; $display("[TB] FAIL rnd_done i=%0d got=%b exp=%b", i, mc_done_o, e_done); end
      checks++; if (stall_cnt_o !== e_cnt) begin failures++; $display("[TB] FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, stall_cnt_o, e_cnt); end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid_busy();
    test_multiply();
    test_back_to_back();
    test_load_use();
    test_flush_abort();
    test_priority_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Merges stall requests from ID (load-use) and from the multi-cycle EX unit (mul/div), plus flush requests from MEM (exception/redirect). Drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Owns the multi-cycle EX occupancy FSM and a saturating stall-cycle counter.

Parameters:
MUL_CYCLES, 3, EX busy cycles for a multiply (>=1, <=2^CNT_W)
DIV_CYCLES, 32, EX busy cycles for a divide (>=1, <=2^CNT_W)
CNT_W, 6, width of the busy down-counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
stallreq_id_i  in  1  ID load-use hazard; hold ID and earlier
ex_mc_req_i  in  1  id_ex currently holds a multi-cycle op (level)
ex_mc_kind_i  in  1  0 = multiply, 1 = divide; valid with ex_mc_req_i
flush_req_i  in  1  MEM-stage exception/redirect; kill younger stages
stall_o  out  6  [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB; 1 = hold
flush_o  out  1  clear IF/ID, ID/EX, EX/MEM to NOP this cycle
mc_busy_o  out  1  FSM in BUSY
mc_done_o  out  1  one-cycle pulse: EX result valid, EX/MEM captures it
stall_cnt_o  out  32  saturating count of cycles with stall_o[0]=1

Behaviour:
- Reset (rst=0, async): FSM=IDLE, cnt=0, stall_cnt_o=0; stall_o, flush_o, mc_busy_o, mc_done_o all 0 while reset is asserted, regardless of inputs.
- FSM states: IDLE, BUSY, DONE.
- IDLE: flush_req_i -> stay IDLE. Else ex_mc_req_i -> BUSY, cnt <= (kind ? DIV_CYCLES : MUL_CYCLES) - 1. Else stay IDLE.
- BUSY: flush_req_i -> IDLE, cnt <= 0 (op aborted, no done pulse). Else cnt==0 -> DONE. Else cnt <= cnt - 1.
- DONE: unconditional -> IDLE. ex_mc_req_i is ignored here because it still reflects the completing op. mc_done_o=1 unless flush_req_i=1.
- Latency: an op of N cycles stalls EX for 1 (IDLE request cycle) + N (BUSY) cycles. The DONE cycle advances the pipe. MUL_CYCLES=3 gives stall on cycles 0..3 and mc_done_o on cycle 4.
- stall_o is combinational from state and inputs, with priority:
  1. flush_req_i=1 -> 6'b000000, flush_o=1.
  2. (IDLE & ex_mc_req_i) | BUSY -> 6'b001111. EX/MEM receives a bubble; MEM/WB keep flowing.
  3. stallreq_id_i=1 -> 6'b000111. ID/EX receives a bubble.
  4. Otherwise 6'b000000.
- An ID stall request concurrent with an EX stall is subsumed by the EX stall and needs no separate handling.
- flush_o = flush_req_i, combinational, masked to 0 during reset.
- mc_busy_o = (state==BUSY), registered state decode.
- stall_cnt_o increments by 1 on each clk edge where stall_o[0]=1 and saturates at 32'hFFFF_FFFF. It is not cleared by flush.
- Reset mid-BUSY: immediate return to IDLE, all stalls drop asynchronously.
- Flush on the same cycle as a new ex_mc_req_i in IDLE: flush wins and BUSY is not entered.

Decomposition:
- Shared defines file gains: StallBus (5:0); stall encodings StallNone, StallFromId, StallFromEx; MC kind codes MulKind/DivKind; FSM state codes McIdle/McBusy/McDone.
- One natural sub-module: mc_counter (load/decrement/zero-detect down-counter, CNT_W wide).
- The stall-cycle counter stays inline.

Test Plan:
- Reset: assert rst=0 mid-BUSY with DIV, cnt=20 -> outputs 0 immediately; after release FSM=IDLE and stall_cnt_o=0.
- Multiply: ex_mc_req_i=1, kind=0 held from cycle 0 -> stall_o=001111 on cycles 0-3, mc_busy_o=1 on cycles 1-3, mc_done_o=1 and stall_o=0 on cycle 4; stall_cnt_o=4.
- Divide back-to-back: two DIV ops with req held continuously -> 33 stall cycles, done pulse, then a second 33-cycle stall starting in the cycle after DONE; exactly 2 done pulses.
- Load-use: stallreq_id_i=1 for 1 cycle in IDLE -> stall_o=000111 for that cycle only; stall_cnt_o +1.
- Flush abort: DIV in BUSY with cnt=10, flush_req_i=1 for one cycle -> flush_o=1, stall_o=0 that cycle, FSM=IDLE next cycle, no mc_done_o pulse.
- Priority/saturation: stallreq_id_i and ex_mc_req_i asserted together -> 001111. Preload stall_cnt_o to 32'hFFFF_FFFE via force and stall 3 cycles -> holds 32'hFFFF_FFFF.
